// File: rtl/frame_load_ctrl_if.sv
//------------------------------------------------------------------------------
// frame_load_ctrl_if : UART-byte in / BRAM-write + status out bundle
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface frame_load_ctrl_if #(
    parameter int ADDR_W = 19
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_frame_error;
    logic [7:0]        wr_data;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_en;
    logic              busy;
    logic              frame_done;
    logic              frame_valid;
    logic              err_frame;
    logic              err_timeout;
    logic [7:0]        frame_count;

    modport master (
        output rx_data, rx_valid, rx_frame_error,
        input  wr_data, wr_addr, wr_en, busy, frame_done, frame_valid,
               err_frame, err_timeout, frame_count
    );

    modport slave (
        input  rx_data, rx_valid, rx_frame_error,
        output wr_data, wr_addr, wr_en, busy, frame_done, frame_valid,
               err_frame, err_timeout, frame_count
    );
endinterface

`default_nettype wire

// File: rtl/frame_load_ctrl.sv
//------------------------------------------------------------------------------
// frame_load_ctrl : hunts a 2-byte sync, then streams PIXELS UART bytes into BRAM
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module frame_load_ctrl #(
    parameter int         PIXELS      = 307200,
    parameter int         ADDR_W      = 19,
    parameter logic [7:0] SYNC0       = 8'hAA,
    parameter logic [7:0] SYNC1       = 8'h55,
    parameter int         TIMEOUT_CYC = 5000000
) (
    input  wire logic              clk,
    input  wire logic              rst,
    frame_load_ctrl_if.slave       bus
);
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [ADDR_W-1:0] c_ADDR_LAST = ADDR_W'(PIXELS - 1);
    localparam logic [TMO_W-1:0]  c_TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SYNC = 2'd1,
        S_LOAD = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic              wr_en_q, wr_en_d;
    logic              busy_q, busy_d;
    logic              frame_done_q, frame_done_d;
    logic              frame_valid_q, frame_valid_d;
    logic              err_frame_q, err_frame_d;
    logic              err_timeout_q, err_timeout_d;
    logic [7:0]        frame_count_q, frame_count_d;

    logic w_accept, w_bad, w_expired;

    assign w_accept  = bus.rx_valid & ~bus.rx_frame_error;
    assign w_bad     = bus.rx_valid &  bus.rx_frame_error;
    // A byte arriving in the expiry cycle wins over the timeout.
    assign w_expired = (tmo_q == c_TMO_LAST) & ~bus.rx_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            addr_q        <= '0;
            tmo_q         <= '0;
            wr_data_q     <= '0;
            wr_addr_q     <= '0;
            wr_en_q       <= 1'b0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_valid_q <= 1'b0;
            err_frame_q   <= 1'b0;
            err_timeout_q <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            tmo_q         <= tmo_d;
            wr_data_q     <= wr_data_d;
            wr_addr_q     <= wr_addr_d;
            wr_en_q       <= wr_en_d;
            busy_q        <= busy_d;
            frame_done_q  <= frame_done_d;
            frame_valid_q <= frame_valid_d;
            err_frame_q   <= err_frame_d;
            err_timeout_q <= err_timeout_d;
            frame_count_q <= frame_count_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wr_data_d     = wr_data_q;
        wr_addr_d     = wr_addr_q;
        wr_en_d       = 1'b0;
        frame_done_d  = 1'b0;
        frame_valid_d = frame_valid_q;
        err_frame_d   = err_frame_q;
        err_timeout_d = err_timeout_q;
        frame_count_d = frame_count_q;

        if (state_q == S_IDLE || bus.rx_valid || w_expired) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end

        // Completion is reported the cycle after the last pixel's write strobe.
        if (wr_en_q && wr_addr_q == c_ADDR_LAST) begin
            frame_done_d  = 1'b1;
            frame_valid_d = 1'b1;
            frame_count_d = frame_count_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (w_accept && bus.rx_data == SYNC0) begin
                    state_d = S_SYNC;
                end
            end
            S_SYNC: begin
                if (w_accept) begin
                    if (bus.rx_data == SYNC1) begin
                        state_d       = S_LOAD;
                        addr_d        = '0;
                        frame_valid_d = 1'b0;
                        err_frame_d   = 1'b0;
                        err_timeout_d = 1'b0;
                    end else if (bus.rx_data != SYNC0) begin
                        state_d = S_IDLE;
                    end
                end else if (w_bad || w_expired) begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                if (w_accept) begin
                    wr_en_d   = 1'b1;
                    wr_data_d = bus.rx_data;
                    wr_addr_d = addr_q;
                    if (addr_q == c_ADDR_LAST) begin
                        state_d = S_IDLE;
                        addr_d  = '0;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                    end
                end else if (w_bad) begin
                    state_d     = S_IDLE;
                    err_frame_d = 1'b1;
                end else if (w_expired) begin
                    state_d       = S_IDLE;
                    err_timeout_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign bus.wr_data     = wr_data_q;
    assign bus.wr_addr     = wr_addr_q;
    assign bus.wr_en       = wr_en_q;
    assign bus.busy        = busy_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.err_frame   = err_frame_q;
    assign bus.err_timeout = err_timeout_q;
    assign bus.frame_count = frame_count_q;

endmodule

`default_nettype wire

// File: tb/tb_frame_load_ctrl.sv
//------------------------------------------------------------------------------
// tb_frame_load_ctrl : directed self-checking bench for frame_load_ctrl
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_frame_load_ctrl;
    localparam int PIX = 16;
    localparam int AW  = 4;
    localparam int TO  = 100;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    logic [7:0]    wdat[$];
    logic [AW-1:0] wadr[$];

    always #5 clk = ~clk;

    frame_load_ctrl_if #(.ADDR_W(AW)) bus ();

    frame_load_ctrl #(
        .PIXELS      (PIX),
        .ADDR_W      (AW),
        .SYNC0       (8'hAA),
        .SYNC1       (8'h55),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Write log sampled on the inactive edge
    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) begin
            wdat.push_back(bus.wr_data);
            wadr.push_back(bus.wr_addr);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic e);
        @(negedge clk);
        bus.rx_data        = b;
        bus.rx_valid       = 1'b1;
        bus.rx_frame_error = e;
        @(negedge clk);
        bus.rx_valid       = 1'b0;
        bus.rx_frame_error = 1'b0;
    endtask

    task automatic clear_log();
        wdat.delete();
        wadr.delete();
    endtask

    // Verifies the logged writes are sequential from address 0 with data base+addr
    task automatic check_log(input string tag, input int n, input logic [7:0] base);
        int bad;
        bad = 0;
        check({tag, "_wr_count"}, 32'(wdat.size()), 32'(n));
        for (int i = 0; i < wdat.size(); i++) begin
            if (wadr[i] !== AW'(i) || wdat[i] !== 8'(base + 8'(i))) bad++;
        end
        check({tag, "_addr_data"}, 32'(bad), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst                = 1'b1;
        bus.rx_data        = 8'h00;
        bus.rx_valid       = 1'b0;
        bus.rx_frame_error = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // 1: reset state, idle with no stimulus
        check("rst_outputs", {bus.wr_data, 4'(bus.wr_addr), bus.wr_en, bus.frame_done,
                              bus.frame_valid, bus.err_frame, bus.err_timeout, bus.frame_count}, 32'd0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_no_writes", 32'(wdat.size()), 32'd0);

        // 2: basic frame, data equals address
        clear_log();
        send(8'hAA, 1'b0);
        send(8'h55, 1'b0);
        check("t2_busy", bus.busy, 1'b1);
        for (int i = 0; i < PIX; i++) send(8'(i), 1'b0);
        check("t2_last_wr_en", bus.wr_en, 1'b1);
        check("t2_done_not_yet", bus.frame_done, 1'b0);
        @(negedge clk);
        check("t2_frame_done", bus.frame_done, 1'b1);
        check("t2_busy_after", bus.busy, 1'b0);
        @(negedge clk);
        check("t2_done_pulse", bus.frame_done, 1'b0);
        check("t2_frame_valid", bus.frame_valid, 1'b1);
        check("t2_frame_count", bus.frame_count, 8'd1);
        check_log("t2", PIX, 8'h00);

        // 3: false starts before the real sync
        clear_log();
        send(8'h12, 1'b0);
        send(8'h55, 1'b0);
        send(8'hAA, 1'b0);
        send(8'hAA, 1'b0);
        check("t3_no_early_write", 32'(wdat.size()), 32'd0);
        check("t3_still_valid", bus.frame_valid, 1'b1);
        send(8'h55, 1'b0);
        check("t3_valid_cleared", bus.frame_valid, 1'b0);
        for (int i = 0; i < PIX; i++) send(8'h30 + 8'(i), 1'b0);
        repeat (2) @(negedge clk);
        check_log("t3", PIX, 8'h30);
        check("t3_frame_count", bus.frame_count, 8'd2);
        check("t3_frame_valid", bus.frame_valid, 1'b1);

        // 4a: 99 idle cycles between bytes is tolerated
        clear_log();
        send(8'hAA, 1'b0);
        send(8'h55, 1'b0);
        for (int i = 0; i < 5; i++) send(8'(i), 1'b0);
        repeat (98) @(negedge clk);
        for (int i = 5; i < PIX; i++) send(8'(i), 1'b0);
        repeat (2) @(negedge clk);
        check_log("t4a", PIX, 8'h00);
        check("t4a_frame_count", bus.frame_count, 8'd3);
        check("t4a_err_timeout", bus.err_timeout, 1'b0);

        // 4b: 100 idle cycles aborts
        clear_log();
        send(8'hAA, 1'b0);
        send(8'h55, 1'b0);
        for (int i = 0; i < 5; i++) send(8'(i), 1'b0);
        repeat (99) @(negedge clk);
        for (int i = 5; i < PIX; i++) send(8'(i), 1'b0);
        repeat (2) @(negedge clk);
        check_log("t4b", 5, 8'h00);
        check("t4b_err_timeout", bus.err_timeout, 1'b1);
        check("t4b_frame_valid", bus.frame_valid, 1'b0);
        check("t4b_busy", bus.busy, 1'b0);
        check("t4b_frame_count", bus.frame_count, 8'd3);
        check("t4b_err_frame", bus.err_frame, 1'b0);

        // 5: frame error on the 8th byte
        clear_log();
        send(8'hAA, 1'b0);
        send(8'h55, 1'b0);
        check("t5_tmo_cleared", bus.err_timeout, 1'b0);
        for (int i = 0; i < 7; i++) send(8'(i), 1'b0);
        send(8'h07, 1'b1);
        repeat (2) @(negedge clk);
        check_log("t5", 7, 8'h00);
        check("t5_err_frame", bus.err_frame, 1'b1);
        check("t5_busy", bus.busy, 1'b0);
        check("t5_frame_valid", bus.frame_valid, 1'b0);
        send(8'hAA, 1'b0);
        check("t5_err_kept_in_sync", bus.err_frame, 1'b1);
        send(8'h55, 1'b0);
        check("t5_err_cleared", bus.err_frame, 1'b0);
        check("t5_busy_load", bus.busy, 1'b1);

        // 6: asynchronous reset after the 8th pixel write
        clear_log();
        for (int i = 0; i < 8; i++) send(8'h80 + 8'(i), 1'b0);
        check("t6_wr_before_rst", bus.wr_en, 1'b1);
        #1 rst = 1'b1;
        #1;
        check("t6_rst_outputs", {bus.wr_data, 4'(bus.wr_addr), bus.wr_en, bus.frame_done,
                                 bus.frame_valid, bus.err_frame, bus.err_timeout, bus.frame_count}, 32'd0);
        check("t6_rst_busy", bus.busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        clear_log();
        send(8'hAA, 1'b0);
        send(8'h55, 1'b0);
        for (int i = 0; i < PIX; i++) send(8'hC0 + 8'(i), 1'b0);
        repeat (2) @(negedge clk);
        check_log("t6", PIX, 8'hC0);
        check("t6_frame_count", bus.frame_count, 8'd1);
        check("t6_frame_valid", bus.frame_valid, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
